// File: rtl/forwarding_source_tracker_if.sv
// Forwarding types plus the ID-stage / forwarding-unit interface of the source tracker.
// Latency: none (signal bundle only).
// Backpressure: none; stalls travel as hazard_stall/global_stall level signals.
package forwarding_pkg;
  typedef enum logic [1:0] {
    NoType  = 2'd0,
    Type1   = 2'd1,
    Type2   = 2'd2,
    Type1_3 = 2'd3
  } forwarding_type_t;

  typedef enum logic [1:0] {
    NoForwarding   = 2'd0,
    ForwardFromEx  = 2'd1,
    ForwardFromMem = 2'd2,
    ForwardFromWb  = 2'd3
  } forwarding_target_t;

  typedef struct packed {
    logic               reg_we;
    logic [4:0]         rd;
    forwarding_target_t target_forwarding;
  } forwarding_src_bundle_t;
endpackage

interface forwarding_source_tracker_if;
  import forwarding_pkg::*;

  logic                   id_valid;
  logic                   id_reg_we;
  logic [4:0]             id_rd;
  forwarding_type_t       id_type;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic                   flush;
  logic                   global_stall;
  forwarding_src_bundle_t ex_src;
  forwarding_src_bundle_t mem_src;
  forwarding_src_bundle_t wb_src;
  logic                   hazard_stall;

  // Pipeline/ID side: drives the ID instruction, consumes the bundles
  modport master (
    output id_valid, id_reg_we, id_rd, id_type, id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2, flush, global_stall,
    input  ex_src, mem_src, wb_src, hazard_stall
  );

  // Tracker side
  modport slave (
    input  id_valid, id_reg_we, id_rd, id_type, id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2, flush, global_stall,
    output ex_src, mem_src, wb_src, hazard_stall
  );
endinterface

// File: rtl/forwarding_source_tracker.sv
// Tracks EX/MEM/WB destination registers, builds per-stage forwarding sources, flags load-use hazards.
// Latency: bundles are registered (1 edge per stage); hazard_stall is combinational in the same cycle.
// Backpressure: global_stall freezes slots and counter; hazard_stall inserts an EX bubble.
module forwarding_source_tracker
  import forwarding_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  forwarding_source_tracker_if.slave fwd_if,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  typedef struct packed {
    logic             valid;
    logic             reg_we;
    logic [4:0]       rd;
    forwarding_type_t typ;
  } slot_t;

  localparam slot_t BUBBLE = '{valid: 1'b0, reg_we: 1'b0, rd: 5'd0, typ: NoType};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;

  forwarding_src_bundle_t ex_b, mem_b, wb_b;
  slot_t capture;
  logic  rs1_hazard, rs2_hazard, hazard;

  // Youngest matching producer decides; an older match never overrides a younger one
  function automatic logic src_hazard(input logic used, input logic [4:0] rs,
                                      input forwarding_src_bundle_t ex,
                                      input forwarding_src_bundle_t mem,
                                      input forwarding_src_bundle_t wb);
    logic h;
    h = 1'b0;
    if (used && rs != 5'd0) begin
      if (ex.reg_we && ex.rd == rs)        h = (ex.target_forwarding == NoForwarding);
      else if (mem.reg_we && mem.rd == rs) h = (mem.target_forwarding == NoForwarding);
      else if (wb.reg_we && wb.rd == rs)   h = (wb.target_forwarding == NoForwarding);
    end
    return h;
  endfunction

  // Per-stage bundles: a result is forwardable only from the stage where its type makes it available
  always_comb begin
    ex_b  = '0;
    mem_b = '0;
    wb_b  = '0;
    ex_b.reg_we  = ex_q.valid & ex_q.reg_we;
    ex_b.rd      = ex_q.rd;
    mem_b.reg_we = mem_q.valid & mem_q.reg_we;
    mem_b.rd     = mem_q.rd;
    wb_b.reg_we  = wb_q.valid & wb_q.reg_we;
    wb_b.rd      = wb_q.rd;
    if (ex_b.reg_we && ex_q.typ == Type1)
      ex_b.target_forwarding = ForwardFromEx;
    if (mem_b.reg_we && (mem_q.typ == Type1 || mem_q.typ == Type2))
      mem_b.target_forwarding = ForwardFromMem;
    if (wb_b.reg_we && wb_q.typ != NoType)
      wb_b.target_forwarding = ForwardFromWb;
  end

  // Hazard detection and ID capture; x0 writes are never tracked
  always_comb begin
    rs1_hazard = src_hazard(fwd_if.id_uses_rs1, fwd_if.id_rs1, ex_b, mem_b, wb_b);
    rs2_hazard = src_hazard(fwd_if.id_uses_rs2, fwd_if.id_rs2, ex_b, mem_b, wb_b);
    hazard     = (rs1_hazard | rs2_hazard) & fwd_if.id_valid & ~fwd_if.flush;
    capture    = BUBBLE;
    if (fwd_if.id_valid) begin
      capture.valid  = 1'b1;
      capture.reg_we = fwd_if.id_reg_we & (fwd_if.id_rd != 5'd0);
      capture.rd     = fwd_if.id_rd;
      capture.typ    = fwd_if.id_type;
    end
  end

  // Next state: advance unless frozen; flush or hazard puts a bubble into EX
  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall_count_q;
    if (!fwd_if.global_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (fwd_if.flush || hazard) ? BUBBLE : capture;
      if (hazard && stall_count_q != {COUNT_WIDTH{1'b1}})
        stall_count_d = stall_count_q + CNT_ONE;
    end
  end

  // Slot and counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q          <= BUBBLE;
      mem_q         <= BUBBLE;
      wb_q          <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_if.ex_src       = ex_b;
  assign fwd_if.mem_src      = mem_b;
  assign fwd_if.wb_src       = wb_b;
  assign fwd_if.hazard_stall = hazard;
  assign stall_count         = stall_count_q;

endmodule

// File: tb/tb_forwarding_source_tracker.sv
// Scoreboarded directed bench for forwarding_source_tracker, plus a narrow-counter copy for saturation.
// Latency: stimulus at posedge+1, monitor compares at negedge of the same cycle.
// Backpressure: exercised through hazard_stall, flush and global_stall vectors.
module tb_forwarding_source_tracker;
  import forwarding_pkg::*;

  typedef struct packed {
    forwarding_src_bundle_t ex;
    forwarding_src_bundle_t mem;
    forwarding_src_bundle_t wb;
    logic                   hz;
    logic [15:0]            cnt;
    logic [2:0]             sat;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] stall_count;
  logic [2:0]  sat_count;
  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  string name_q[$];

  forwarding_source_tracker_if fs_if ();
  forwarding_source_tracker_if sat_if ();

  assign sat_if.id_valid     = fs_if.id_valid;
  assign sat_if.id_reg_we    = fs_if.id_reg_we;
  assign sat_if.id_rd        = fs_if.id_rd;
  assign sat_if.id_type      = fs_if.id_type;
  assign sat_if.id_rs1       = fs_if.id_rs1;
  assign sat_if.id_rs2       = fs_if.id_rs2;
  assign sat_if.id_uses_rs1  = fs_if.id_uses_rs1;
  assign sat_if.id_uses_rs2  = fs_if.id_uses_rs2;
  assign sat_if.flush        = fs_if.flush;
  assign sat_if.global_stall = fs_if.global_stall;

  forwarding_source_tracker #(.COUNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .fwd_if(fs_if.slave), .stall_count(stall_count)
  );

  forwarding_source_tracker #(.COUNT_WIDTH(3)) dut_sat (
    .clock(clock), .reset_n(reset_n), .fwd_if(sat_if.slave), .stall_count(sat_count)
  );

  always #5 clock = ~clock;

  localparam forwarding_src_bundle_t Z = '0;

  function automatic forwarding_src_bundle_t fx(input logic [4:0] rd);
    return '{reg_we: 1'b1, rd: rd, target_forwarding: ForwardFromEx};
  endfunction
  function automatic forwarding_src_bundle_t fm(input logic [4:0] rd);
    return '{reg_we: 1'b1, rd: rd, target_forwarding: ForwardFromMem};
  endfunction
  function automatic forwarding_src_bundle_t fw(input logic [4:0] rd);
    return '{reg_we: 1'b1, rd: rd, target_forwarding: ForwardFromWb};
  endfunction
  function automatic forwarding_src_bundle_t nf(input logic [4:0] rd);
    return '{reg_we: 1'b1, rd: rd, target_forwarding: NoForwarding};
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.ex  = fs_if.ex_src;
    o.mem = fs_if.mem_src;
    o.wb  = fs_if.wb_src;
    o.hz  = fs_if.hazard_stall;
    o.cnt = stall_count;
    o.sat = sat_count;
    return o;
  endfunction

  task automatic compare(input string nm, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got ex=%h mem=%h wb=%h hz=%b cnt=%0d sat=%0d required ex=%h mem=%h wb=%h hz=%b cnt=%0d sat=%0d",
               nm, got.ex, got.mem, got.wb, got.hz, got.cnt, got.sat,
               want.ex, want.mem, want.wb, want.hz, want.cnt, want.sat);
    end
  endtask

  // Monitor: every cycle that has a pending expectation is checked mid-cycle
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) compare(name_q.pop_front(), observed(), exp_q.pop_front());
    end
  end

  task automatic drive_id(input logic v, input logic we, input logic [4:0] rd,
                          input forwarding_type_t ty, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    fs_if.id_valid    = v;
    fs_if.id_reg_we   = we;
    fs_if.id_rd       = rd;
    fs_if.id_type     = ty;
    fs_if.id_rs1      = rs1;
    fs_if.id_uses_rs1 = u1;
    fs_if.id_rs2      = rs2;
    fs_if.id_uses_rs2 = u2;
  endtask

  task automatic idle();
    drive_id(1'b0, 1'b0, 5'd0, NoType, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic push_exp(input string nm, input forwarding_src_bundle_t e,
                          input forwarding_src_bundle_t m, input forwarding_src_bundle_t w,
                          input logic hz, input logic [15:0] c, input logic [2:0] s);
    exp_t x;
    x.ex = e; x.mem = m; x.wb = w; x.hz = hz; x.cnt = c; x.sat = s;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic expc(input string nm, input forwarding_src_bundle_t e,
                      input forwarding_src_bundle_t m, input forwarding_src_bundle_t w,
                      input logic hz, input logic [15:0] c, input logic [2:0] s);
    push_exp(nm, e, m, w, hz, c, s);
    @(posedge clock);
    #1;
  endtask

  // CSR rd=3 followed by a non-writing consumer of rs2=3; starts and ends with empty slots
  task automatic csr_use(input string nm, input logic [15:0] c0, input logic [15:0] c1,
                         input logic [15:0] c2, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [2:0] s2);
    drive_id(1'b1, 1'b1, 5'd3, Type1_3, 5'd0, 1'b0, 5'd0, 1'b0);
    expc({nm, "_cap"}, Z, Z, Z, 1'b0, c0, s0);
    drive_id(1'b1, 1'b0, 5'd0, Type1, 5'd0, 1'b0, 5'd3, 1'b1);
    expc({nm, "_stall_ex"}, nf(5'd3), Z, Z, 1'b1, c0, s0);
    expc({nm, "_stall_mem"}, Z, nf(5'd3), Z, 1'b1, c1, s1);
    expc({nm, "_fwd_wb"}, Z, Z, fw(5'd3), 1'b0, c2, s2);
    idle();
    expc({nm, "_drain"}, Z, Z, Z, 1'b0, c2, s2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t zero;
    zero = '0;
    idle();
    fs_if.flush = 1'b0;
    fs_if.global_stall = 1'b0;
    #3;
    compare("reset_initial", observed(), zero);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) expc("reset_idle", Z, Z, Z, 1'b0, 16'd0, 3'd0);

    // ALU rd=5 walks through the three stages
    drive_id(1'b1, 1'b1, 5'd5, Type1, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("alu_cap", Z, Z, Z, 1'b0, 16'd0, 3'd0);
    idle();
    expc("alu_ex", fx(5'd5), Z, Z, 1'b0, 16'd0, 3'd0);
    expc("alu_mem", Z, fm(5'd5), Z, 1'b0, 16'd0, 3'd0);
    expc("alu_wb", Z, Z, fw(5'd5), 1'b0, 16'd0, 3'd0);
    expc("alu_gone", Z, Z, Z, 1'b0, 16'd0, 3'd0);

    // Load rd=7 then consumer of rs1=7: one stall cycle
    drive_id(1'b1, 1'b1, 5'd7, Type2, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("ld_cap", Z, Z, Z, 1'b0, 16'd0, 3'd0);
    drive_id(1'b1, 1'b1, 5'd10, Type1, 5'd7, 1'b1, 5'd0, 1'b0);
    expc("ld_use_stall", nf(5'd7), Z, Z, 1'b1, 16'd0, 3'd0);
    expc("ld_use_bubble", Z, fm(5'd7), Z, 1'b0, 16'd1, 3'd1);
    idle();
    expc("ld_use_go", fx(5'd10), Z, fw(5'd7), 1'b0, 16'd1, 3'd1);
    expc("ld_drain1", Z, fm(5'd10), Z, 1'b0, 16'd1, 3'd1);
    expc("ld_drain2", Z, Z, fw(5'd10), 1'b0, 16'd1, 3'd1);
    expc("ld_drain3", Z, Z, Z, 1'b0, 16'd1, 3'd1);

    // CSR late result: two stall cycles
    csr_use("csr", 16'd1, 16'd2, 16'd3, 3'd1, 3'd2, 3'd3);

    // CSR rd=3, then ALU rd=3, then consumer: youngest (ALU) match forwards, no stall
    drive_id(1'b1, 1'b1, 5'd3, Type1_3, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("yw_csr", Z, Z, Z, 1'b0, 16'd3, 3'd3);
    drive_id(1'b1, 1'b1, 5'd3, Type1, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("yw_alu", nf(5'd3), Z, Z, 1'b0, 16'd3, 3'd3);
    drive_id(1'b1, 1'b1, 5'd12, Type1, 5'd0, 1'b0, 5'd3, 1'b1);
    expc("yw_use", fx(5'd3), nf(5'd3), Z, 1'b0, 16'd3, 3'd3);
    idle();
    expc("yw_d1", fx(5'd12), fm(5'd3), fw(5'd3), 1'b0, 16'd3, 3'd3);
    expc("yw_d2", Z, fm(5'd12), fw(5'd3), 1'b0, 16'd3, 3'd3);
    expc("yw_d3", Z, Z, fw(5'd12), 1'b0, 16'd3, 3'd3);
    expc("yw_d4", Z, Z, Z, 1'b0, 16'd3, 3'd3);

    // Flush beats the hazard
    drive_id(1'b1, 1'b1, 5'd9, Type2, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("fl_cap", Z, Z, Z, 1'b0, 16'd3, 3'd3);
    drive_id(1'b1, 1'b1, 5'd14, Type1, 5'd9, 1'b1, 5'd0, 1'b0);
    fs_if.flush = 1'b1;
    expc("fl_no_stall", nf(5'd9), Z, Z, 1'b0, 16'd3, 3'd3);
    fs_if.flush = 1'b0;
    idle();
    expc("fl_bubble", Z, fm(5'd9), Z, 1'b0, 16'd3, 3'd3);
    expc("fl_d1", Z, Z, fw(5'd9), 1'b0, 16'd3, 3'd3);
    expc("fl_d2", Z, Z, Z, 1'b0, 16'd3, 3'd3);

    // Load to x0 is never tracked
    drive_id(1'b1, 1'b1, 5'd0, Type2, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("x0_cap", Z, Z, Z, 1'b0, 16'd3, 3'd3);
    drive_id(1'b1, 1'b0, 5'd0, Type1, 5'd0, 1'b1, 5'd0, 1'b0);
    expc("x0_ex", Z, Z, Z, 1'b0, 16'd3, 3'd3);
    idle();
    expc("x0_mem", Z, Z, Z, 1'b0, 16'd3, 3'd3);
    expc("x0_wb", Z, Z, Z, 1'b0, 16'd3, 3'd3);

    // Global stall during a load-use hazard freezes slots and count
    drive_id(1'b1, 1'b1, 5'd7, Type2, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("gs_cap", Z, Z, Z, 1'b0, 16'd3, 3'd3);
    drive_id(1'b1, 1'b1, 5'd20, Type1, 5'd7, 1'b1, 5'd0, 1'b0);
    fs_if.global_stall = 1'b1;
    for (int i = 0; i < 4; i++) expc("gs_frozen", nf(5'd7), Z, Z, 1'b1, 16'd3, 3'd3);
    fs_if.global_stall = 1'b0;
    expc("gs_release", nf(5'd7), Z, Z, 1'b1, 16'd3, 3'd3);
    expc("gs_bubble", Z, fm(5'd7), Z, 1'b0, 16'd4, 3'd4);
    idle();
    expc("gs_go", fx(5'd20), Z, fw(7), 1'b0, 16'd4, 3'd4);

    // Reset in the middle of a cycle clears everything immediately
    push_exp("pre_reset", Z, fm(5'd20), Z, 1'b0, 16'd4, 3'd4);
    #6;
    reset_n = 1'b0;
    #1;
    compare("mid_reset", observed(), zero);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    expc("post_reset", Z, Z, Z, 1'b0, 16'd0, 3'd0);

    // Narrow counter: climb to 6, then saturate at 7 while stalls continue
    csr_use("sat_a", 16'd0, 16'd1, 16'd2, 3'd0, 3'd1, 3'd2);
    csr_use("sat_b", 16'd2, 16'd3, 16'd4, 3'd2, 3'd3, 3'd4);
    csr_use("sat_c", 16'd4, 16'd5, 16'd6, 3'd4, 3'd5, 3'd6);
    csr_use("sat_d", 16'd6, 16'd7, 16'd8, 3'd6, 3'd7, 3'd7);
    csr_use("sat_e", 16'd8, 16'd9, 16'd10, 3'd7, 3'd7, 3'd7);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
